rs_stream_tx: RTL and testbench

Burst transmitter for the valid/ready register-slice path: drives the source side (`dvalid`/`dready`/`ddata`) that a register slice accepts. On each accepted command it emits `cmd_len+1` data beats, either incrementing from a seed or a constant seed value. It holds data stable under backpressure and can insert a programmable bubble between beats. It is the standard stimulus source and upstream producer for register-slice and FIFO blocks.

---
 rtl/rs_stream_pkg.sv | 13 +
 rtl/rs_stream_tx.sv | 157 +++++++++++++++
 tb/tb_rs_stream_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_stream_pkg.sv
// Shared types for the valid/ready stream source and register-slice benches.
package rs_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10
  } state_t;

  localparam logic MODE_INC   = 1'b0;
  localparam logic MODE_CONST = 1'b1;

endpackage

// File: rtl/rs_stream_tx.sv
// Burst transmitter: on each accepted command emits cmd_len+1 beats
// (incrementing or constant), holds data under backpressure and can
// insert GAP idle cycles between beats. All outputs are registered.
module rs_stream_tx
  import rs_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned GAP    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  input  logic              cmd_mode,
  output logic              dvalid,
  input  logic              dready,
  output logic [DATA_W-1:0] ddata,
  output logic              dlast,
  output logic              burst_done,
  output logic [1:0]        state
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              dvalid_q, dvalid_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              dlast_q, dlast_d;
  logic              burst_done_q, burst_done_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              mode_q, mode_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [DATA_W-1:0] next_data;
  logic [LEN_W-1:0]  cnt_inc;

  // Successor beat value and beat index derived from the current beat.
  always_comb begin
    next_data = (mode_q == MODE_CONST) ? ddata_q : ddata_q + DATA_W'(1);
    cnt_inc   = cnt_q + LEN_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    dvalid_d     = dvalid_q;
    ddata_d      = ddata_q;
    dlast_d      = dlast_q;
    burst_done_d = 1'b0;
    len_d        = len_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        dvalid_d    = 1'b0;
        dlast_d     = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          len_d       = cmd_len;
          mode_d      = cmd_mode;
          ddata_d     = cmd_seed;
          cnt_d       = '0;
          dvalid_d    = 1'b1;
          dlast_d     = (cmd_len == '0);
          cmd_ready_d = 1'b0;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (dvalid_q && dready) begin
          if (dlast_q) begin
            dvalid_d     = 1'b0;
            dlast_d      = 1'b0;
            cmd_ready_d  = 1'b1;
            burst_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (GAP == 0) begin
              ddata_d = next_data;
              dlast_d = (cnt_inc == len_q);
            end else begin
              // ddata keeps the sent beat through the gap; the counter is
              // already advanced so dlast is decided from cnt_q on exit.
              dvalid_d = 1'b0;
              gap_d    = '0;
              state_d  = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          ddata_d  = next_data;
          dlast_d  = (cnt_q == len_q);
          dvalid_d = 1'b1;
          state_d  = S_SEND;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b0;
        dvalid_d    = 1'b0;
        dlast_d     = 1'b0;
        ddata_d     = '0;
        cnt_d       = '0;
        gap_d       = '0;
      end
    endcase
  end

  // FSM, counters and data register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      dvalid_q     <= 1'b0;
      ddata_q      <= '0;
      dlast_q      <= 1'b0;
      burst_done_q <= 1'b0;
      len_q        <= '0;
      mode_q       <= MODE_INC;
      cnt_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      dvalid_q     <= dvalid_d;
      ddata_q      <= ddata_d;
      dlast_q      <= dlast_d;
      burst_done_q <= burst_done_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign dvalid     = dvalid_q;
  assign ddata      = ddata_q;
  assign dlast      = dlast_q;
  assign burst_done = burst_done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rs_stream_tx.sv
// Directed bench for rs_stream_tx: two instances (GAP=0 and GAP=2) with a
// beat scoreboard per instance, popped on every observed handshake.
module tb_rs_stream_tx;
  import rs_stream_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rstn;

  logic        c0_valid, c0_ready, c0_mode, d0_valid, d0_ready, d0_last, d0_done;
  logic [7:0]  c0_len;
  logic [31:0] c0_seed, d0_data;
  logic [1:0]  s0;

  logic        c2_valid, c2_ready, c2_mode, d2_valid, d2_ready, d2_last, d2_done;
  logic [7:0]  c2_len;
  logic [31:0] c2_seed, d2_data;
  logic [1:0]  s2;

  beat_t q0[$];
  beat_t q2[$];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rs_stream_tx #(.DATA_W(32), .LEN_W(8), .GAP(0)) u0 (
    .clk(clk), .rstn(rstn),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_len(c0_len),
    .cmd_seed(c0_seed), .cmd_mode(c0_mode),
    .dvalid(d0_valid), .dready(d0_ready), .ddata(d0_data), .dlast(d0_last),
    .burst_done(d0_done), .state(s0)
  );

  rs_stream_tx #(.DATA_W(32), .LEN_W(8), .GAP(2)) u2 (
    .clk(clk), .rstn(rstn),
    .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_len(c2_len),
    .cmd_seed(c2_seed), .cmd_mode(c2_mode),
    .dvalid(d2_valid), .dready(d2_ready), .ddata(d2_data), .dlast(d2_last),
    .burst_done(d2_done), .state(s2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitors: a beat is taken at the next posedge when valid and
  // ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1 && d0_valid === 1'b1 && d0_ready === 1'b1) begin
      beat_t e;
      nvec++;
      assert (q0.size() > 0) else begin
        nerr++;
        $error("FAIL u0_extra_beat: observed %0h expected none", d0_data);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        nvec++;
        assert ({d0_data, d0_last} === e) else begin
          nerr++;
          $error("FAIL u0_beat: observed %0h/%0b expected %0h/%0b", d0_data, d0_last, e.d, e.l);
        end
      end
    end
    if (rstn === 1'b1 && d2_valid === 1'b1 && d2_ready === 1'b1) begin
      beat_t e;
      nvec++;
      assert (q2.size() > 0) else begin
        nerr++;
        $error("FAIL u2_extra_beat: observed %0h expected none", d2_data);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        nvec++;
        assert ({d2_data, d2_last} === e) else begin
          nerr++;
          $error("FAIL u2_beat: observed %0h/%0b expected %0h/%0b", d2_data, d2_last, e.d, e.l);
        end
      end
    end
  end

  initial begin
    bit pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rstn = 1'b0;
    c0_valid = 1'b0; c0_len = '0; c0_seed = '0; c0_mode = 1'b0; d0_ready = 1'b0;
    c2_valid = 1'b0; c2_len = '0; c2_seed = '0; c2_mode = 1'b0; d2_ready = 1'b0;

    // Reset state
    #12;
    check("rst_cmd_ready", 64'(c0_ready), 64'd0);
    check("rst_dvalid", 64'(d0_valid), 64'd0);
    check("rst_ddata", 64'(d0_data), 64'd0);
    check("rst_dlast", 64'(d0_last), 64'd0);
    check("rst_done", 64'(d0_done), 64'd0);
    check("rst_state", 64'(s0), 64'(S_IDLE));
    check("rst_u2_ready", 64'(c2_ready), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("idle_cmd_ready", 64'(c0_ready), 64'd1);
    check("idle_dvalid", 64'(d0_valid), 64'd0);

    // Incrementing burst, len=3, full throughput
    c0_valid = 1'b1; c0_len = 8'd3; c0_seed = 32'h10; c0_mode = MODE_INC; d0_ready = 1'b1;
    for (int k = 0; k < 4; k++) q0.push_back({32'h10 + 32'(k), k == 3});
    tick();
    c0_valid = 1'b0;
    check("a_first_valid", 64'(d0_valid), 64'd1);
    check("a_first_data", 64'(d0_data), 64'h10);
    check("a_first_last", 64'(d0_last), 64'd0);
    check("a_busy_ready", 64'(c0_ready), 64'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("a_b2b_valid", 64'(d0_valid), 64'd1);
    end
    check("a_last_flag", 64'(d0_last), 64'd1);
    tick();
    check("a_done", 64'(d0_done), 64'd1);
    check("a_ready_back", 64'(c0_ready), 64'd1);
    check("a_valid_off", 64'(d0_valid), 64'd0);
    check("a_data_hold", 64'(d0_data), 64'h13);
    tick();
    check("a_done_pulse", 64'(d0_done), 64'd0);

    // Same burst under backpressure
    c0_valid = 1'b1;
    for (int k = 0; k < 4; k++) q0.push_back({32'h10 + 32'(k), k == 3});
    tick();
    c0_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("b_valid_held", 64'(d0_valid), 64'd1);
      d0_ready = pat[i];
      tick();
    end
    check("b_done", 64'(d0_done), 64'd1);
    check("b_valid_off", 64'(d0_valid), 64'd0);
    d0_ready = 1'b1;

    // GAP=2 with wrap from all-ones
    c2_valid = 1'b1; c2_len = 8'd1; c2_seed = 32'hFFFF_FFFF; c2_mode = MODE_INC; d2_ready = 1'b1;
    q2.push_back({32'hFFFF_FFFF, 1'b0});
    q2.push_back({32'h0, 1'b1});
    tick();
    c2_valid = 1'b0;
    check("g_first_valid", 64'(d2_valid), 64'd1);
    tick();
    check("g_gap1", 64'(d2_valid), 64'd0);
    check("g_gap_state", 64'(s2), 64'(S_GAP));
    tick();
    check("g_gap2", 64'(d2_valid), 64'd0);
    tick();
    check("g_second_valid", 64'(d2_valid), 64'd1);
    check("g_second_data", 64'(d2_data), 64'h0);
    tick();
    check("g_done", 64'(d2_done), 64'd1);

    // Max-length constant burst with cmd_valid held; new command waits
    c0_valid = 1'b1; c0_len = 8'd255; c0_seed = 32'hA5; c0_mode = MODE_CONST;
    for (int k = 0; k < 256; k++) q0.push_back({32'hA5, k == 255});
    tick();
    c0_len = 8'd0; c0_seed = 32'h55; c0_mode = MODE_CONST;
    q0.push_back({32'h55, 1'b1});
    for (int k = 0; k < 256; k++) begin
      check("m_busy_ready", 64'(c0_ready), 64'd0);
      check("m_valid", 64'(d0_valid), 64'd1);
      tick();
    end
    check("m_done", 64'(d0_done), 64'd1);
    check("m_ready_back", 64'(c0_ready), 64'd1);
    check("m_valid_gap", 64'(d0_valid), 64'd0);
    tick();
    c0_valid = 1'b0;
    check("m2_valid", 64'(d0_valid), 64'd1);
    check("m2_data", 64'(d0_data), 64'h55);
    check("m2_last", 64'(d0_last), 64'd1);
    tick();
    check("m2_done", 64'(d0_done), 64'd1);

    // Reset during beat 2 of a len=7 burst
    c0_valid = 1'b1; c0_len = 8'd7; c0_seed = 32'h100; c0_mode = MODE_INC;
    q0.push_back({32'h100, 1'b0});
    tick();
    c0_valid = 1'b0;
    tick();
    check("r_beat2_data", 64'(d0_data), 64'h101);
    #1 rstn = 1'b0;
    #1;
    check("r_dvalid_drop", 64'(d0_valid), 64'd0);
    check("r_dlast_drop", 64'(d0_last), 64'd0);
    check("r_ready_drop", 64'(c0_ready), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("r_state_idle", 64'(s0), 64'(S_IDLE));
    check("r_ready_after", 64'(c0_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("r_no_beats", 64'(d0_valid), 64'd0);
      tick();
    end

    check("sb_u0_empty", 64'(q0.size()), 64'd0);
    check("sb_u2_empty", 64'(q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
